fetch_buffer: RTL and testbench

- Circular instruction FIFO between the fetch stage and the decode stage.
- Absorbs fetch bursts, decouples fetch from decode back-pressure, and presents one instruction per cycle to decode.
- Outputs map directly onto decode's i_instr, i_en and i_imask inputs.
- Flushed on branch/jump redirect, which discards all wrong-path instructions.

---
 rtl/fetch_buffer_pkg.sv | 7 +
 rtl/fetch_buffer_fifo_ptr.sv | 35 +++
 rtl/fetch_buffer.sv | 77 +++++++
 tb/tb_fetch_buffer.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_buffer_pkg.sv
// Shared constants for the fetch buffer: default depth and the canonical NOP word.
package fetch_buffer_pkg;

    localparam int unsigned FB_DEPTH = 8;
    localparam logic [31:0] NOP      = 32'h0000_0013;

endpackage

// File: rtl/fetch_buffer_fifo_ptr.sv
// Circular-buffer pointer: AW index bits plus a wrap bit, with clear and increment.
module fifo_ptr #(
    parameter int unsigned AW = 3
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_clr,
    input  logic          i_inc,
    output logic [AW:0]   o_ptr
);

    logic [AW:0] ptr_q;
    logic [AW:0] ptr_d;

    // Clear wins so a redirect discards any same-cycle advance.
    always_comb begin
        ptr_d = ptr_q;
        if (i_clr) begin
            ptr_d = '0;
        end else if (i_inc) begin
            ptr_d = ptr_q + (AW + 1)'(1);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign o_ptr = ptr_q;

endmodule

// File: rtl/fetch_buffer.sv
// Circular instruction FIFO between fetch and decode; head is presented combinationally
// and the whole buffer is discarded on a redirect flush.
module fetch_buffer
    import fetch_buffer_pkg::*;
#(
    parameter int unsigned DEPTH    = FB_DEPTH,
    parameter int unsigned WIDTH_PC = 32
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [31:0]                 i_instr,
    input  logic [WIDTH_PC-1:0]         i_pc,
    input  logic                        i_valid,
    output logic                        o_ready,
    output logic [31:0]                 o_instr,
    output logic [WIDTH_PC-1:0]         o_pc,
    output logic                        o_en,
    output logic                        o_imask,
    input  logic                        i_stall,
    input  logic                        i_flush,
    output logic [$clog2(DEPTH):0]      o_count
);

    localparam int unsigned AW = $clog2(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("fetch_buffer: DEPTH must be a power of two and at least 2");
    end

    logic [31:0]         instr_q [DEPTH];
    logic [WIDTH_PC-1:0] pc_q    [DEPTH];

    logic [AW:0] wptr;
    logic [AW:0] rptr;
    logic        full;
    logic        empty;
    logic        push;
    logic        pop;

    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign empty = (wptr == rptr);
    assign pop   = o_en & ~i_stall;
    // A pop frees a slot in the same cycle, so a full buffer still accepts a push.
    assign o_ready = ~full | pop;
    assign push    = i_valid & o_ready;

    fifo_ptr #(.AW(AW)) u_wptr (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_clr (i_flush),
        .i_inc (push),
        .o_ptr (wptr)
    );

    fifo_ptr #(.AW(AW)) u_rptr (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_clr (i_flush),
        .i_inc (pop),
        .o_ptr (rptr)
    );

    always_ff @(posedge i_clk) begin
        if (push && !i_flush) begin
            instr_q[wptr[AW-1:0]] <= i_instr;
            pc_q[wptr[AW-1:0]]    <= i_pc;
        end
    end

    assign o_en    = ~empty;
    // The head is squashed in the flush cycle while o_en still shows pre-flush occupancy.
    assign o_imask = ~empty & ~i_flush;
    assign o_instr = empty ? '0 : instr_q[rptr[AW-1:0]];
    assign o_pc    = empty ? '0 : pc_q[rptr[AW-1:0]];
    assign o_count = wptr - rptr;

endmodule

// File: tb/tb_fetch_buffer.sv
// Scoreboard bench for fetch_buffer: directed scenarios followed by random traffic.
module tb_fetch_buffer;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned WPC   = 32;

    typedef struct {
        logic [31:0]    instr;
        logic [WPC-1:0] pc;
    } entry_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [31:0]       i_instr = '0;
    logic [WPC-1:0]    i_pc = '0;
    logic              i_valid = 1'b0;
    logic              i_stall = 1'b0;
    logic              i_flush = 1'b0;
    logic              o_ready;
    logic [31:0]       o_instr;
    logic [WPC-1:0]    o_pc;
    logic              o_en;
    logic              o_imask;
    logic [3:0]        o_count;

    int vectors = 0;
    int miscompares = 0;
    entry_t exp_q[$];

    fetch_buffer #(.DEPTH(DEPTH), .WIDTH_PC(WPC)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_instr (i_instr),
        .i_pc    (i_pc),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .o_instr (o_instr),
        .o_pc    (o_pc),
        .o_en    (o_en),
        .o_imask (o_imask),
        .i_stall (i_stall),
        .i_flush (i_flush),
        .o_count (o_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a bounded FIFO of accepted entries; flush or reset empties it.
    always @(posedge clk) begin
        if (rst || i_flush) begin
            exp_q.delete();
        end else if (i_valid && exp_q.size() < DEPTH) begin
            exp_q.push_back('{instr: i_instr, pc: i_pc});
        end
    end

    // Monitor: compares the presented head against the scoreboard and retires it on a pop.
    always @(negedge clk) begin
        if (!rst) begin
            automatic int  sz   = exp_q.size();
            automatic bit  en   = (sz != 0);
            automatic bit  popx = en && !i_stall;
            check("o_en",    64'(o_en),    64'(en));
            check("o_imask", 64'(o_imask), 64'(en && !i_flush));
            check("o_count", 64'(o_count), 64'(sz));
            check("o_ready", 64'(o_ready), 64'((sz < DEPTH) || popx));
            if (en) begin
                check("o_instr", 64'(o_instr), 64'(exp_q[0].instr));
                check("o_pc",    64'(o_pc),    64'(exp_q[0].pc));
            end else begin
                check("o_instr_empty", 64'(o_instr), 64'd0);
                check("o_pc_empty",    64'(o_pc),    64'd0);
            end
            if (popx) void'(exp_q.pop_front());
        end
    end

    task automatic step(input logic v, input logic [31:0] ins, input logic [WPC-1:0] pc,
                        input logic st, input logic fl);
        i_valid = v;
        i_instr = ins;
        i_pc    = pc;
        i_stall = st;
        i_flush = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_en"},    64'(o_en),    64'd0);
        check({tag, "_imask"}, 64'(o_imask), 64'd0);
        check({tag, "_count"}, 64'(o_count), 64'd0);
        check({tag, "_ready"}, 64'(o_ready), 64'd1);
        check({tag, "_instr"}, 64'(o_instr), 64'd0);
        check({tag, "_pc"},    64'(o_pc),    64'd0);
    endtask

    initial begin
        #2;
        reset_checks("rst_init");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Empty latency: head appears only after the pushing edge.
        check("lat_before_en", 64'(o_en), 64'd0);
        step(1'b1, 32'hCAFE_0001, 32'h0000_0040, 1'b1, 1'b0);
        check("lat_after_en",    64'(o_en),    64'd1);
        check("lat_after_instr", 64'(o_instr), 64'hCAFE_0001);
        idle(2);

        // Fill under stall, refuse a ninth push, then drain in order.
        for (int k = 0; k < DEPTH; k++)
            step(1'b1, 32'h13 + 32'(k), 32'h100 + 32'(4 * k), 1'b1, 1'b0);
        check("fill_ready", 64'(o_ready), 64'd0);
        check("fill_count", 64'(o_count), 64'd8);
        step(1'b1, 32'hDEAD_BEEF, 32'hFFFF_FFF0, 1'b1, 1'b0);
        check("ninth_refused_count", 64'(o_count), 64'd8);
        for (int k = 0; k < DEPTH; k++) begin
            check("drain_instr", 64'(o_instr), 64'(32'h13 + 32'(k)));
            step(1'b0, '0, '0, 1'b0, 1'b0);
        end
        check("drain_empty_en", 64'(o_en), 64'd0);

        // Full with concurrent push and pop.
        for (int k = 0; k < DEPTH; k++)
            step(1'b1, 32'h200 + 32'(k), 32'h2000 + 32'(4 * k), 1'b1, 1'b0);
        check("full_ready_on_pop_stall", 64'(o_ready), 64'd0);
        i_stall = 1'b0;
        #1;
        check("full_ready_with_pop", 64'(o_ready), 64'd1);
        step(1'b1, 32'h2FF, 32'h2FFC, 1'b0, 1'b0);
        check("full_pp_count", 64'(o_count), 64'd8);
        check("full_pp_head",  64'(o_instr), 64'h201);
        idle(DEPTH + 1);

        // Wrap-around: continuous push with decode always accepting.
        for (int k = 0; k < 20; k++)
            step(1'b1, 32'h300 + 32'(k), 32'h3000 + 32'(4 * k), 1'b0, 1'b0);
        idle(2);

        // Flush at count 5 with a concurrent push.
        for (int k = 0; k < 5; k++)
            step(1'b1, 32'h400 + 32'(k), 32'h4000 + 32'(4 * k), 1'b1, 1'b0);
        check("pre_flush_count", 64'(o_count), 64'd5);
        i_flush = 1'b1;
        i_valid = 1'b1;
        i_instr = 32'h0BAD_0BAD;
        #1;
        check("flush_cycle_imask", 64'(o_imask), 64'd0);
        check("flush_cycle_en",    64'(o_en),    64'd1);
        step(1'b1, 32'h0BAD_0BAD, 32'h4444, 1'b0, 1'b1);
        check("post_flush_count", 64'(o_count), 64'd0);
        check("post_flush_en",    64'(o_en),    64'd0);
        check("post_flush_ready", 64'(o_ready), 64'd1);
        step(1'b1, 32'h500, 32'h5000, 1'b0, 1'b0);
        check("post_flush_head", 64'(o_instr), 64'h500);
        idle(2);

        // Asynchronous reset mid-stream.
        for (int k = 0; k < 3; k++)
            step(1'b1, 32'h600 + 32'(k), 32'h6000 + 32'(4 * k), 1'b1, 1'b0);
        i_valid = 1'b0;
        #2;
        rst = 1'b1;
        exp_q.delete();
        #1;
        reset_checks("rst_mid");
        @(posedge clk);
        #1;
        rst = 1'b0;
        i_stall = 1'b0;

        // Random traffic.
        for (int k = 0; k < 400; k++) begin
            step(1'($urandom_range(0, 3) != 0), $urandom, $urandom,
                 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 19) == 0));
        end
        idle(DEPTH + 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
